// File: rtl/req_nodeset_sink_if.sv
// rtl/req_nodeset_sink_if.sv - request-side and node-side handshake bundle for req_nodeset_sink
interface req_nodeset_sink_if #(
   parameter int PAYLOAD_WIDTH = 16,
   parameter int NODETAG_WIDTH = 6
);
   logic                     i_req_vld;
   logic [PAYLOAD_WIDTH-1:0] i_req_payload;
   logic [NODETAG_WIDTH-1:0] i_req_nodenum;
   logic                     o_req_ack;
   logic                     o_node_vld;
   logic [PAYLOAD_WIDTH-1:0] o_node_payload;
   logic [NODETAG_WIDTH-1:0] o_node_tag;
   logic                     i_node_ack;

   modport slave (
      input  i_req_vld, i_req_payload, i_req_nodenum, i_node_ack,
      output o_req_ack, o_node_vld, o_node_payload, o_node_tag
   );

   modport master (
      output i_req_vld, i_req_payload, i_req_nodenum, i_node_ack,
      input  o_req_ack, o_node_vld, o_node_payload, o_node_tag
   );
endinterface

// File: rtl/req_nodeset_sink.sv
// rtl/req_nodeset_sink.sv - buffered request sink with drain FSM; REQ_NODESET_SINK_STATS_EN enables the accept counter
module req_nodeset_sink #(
   parameter int PAYLOAD_WIDTH = 16,
   parameter int NODETAG_WIDTH = 6,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   req_nodeset_sink_if.slave             bus,
   input  logic                          i_drain,
   output logic                          o_drained,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic [15:0]                   o_stat_accepted
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = PAYLOAD_WIDTH + NODETAG_WIDTH;

   typedef enum logic [1:0] {ACTIVE, DRAIN, IDLE} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] head;
   logic          full, empty, push, pop, req_ack, drained;

   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty   = (wr_ptr == rd_ptr);
   assign o_count = wr_ptr - rd_ptr;
   assign push    = req_ack;
   assign pop     = !empty && bus.i_node_ack;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ACTIVE;
      end else begin
         state_q <= state_d;
      end
   end

   // leaving drain on a deasserted request wins over reaching idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACTIVE:  if (i_drain) state_d = DRAIN;
         DRAIN: begin
            if (!i_drain)           state_d = ACTIVE;
            else if (o_count == '0) state_d = IDLE;
         end
         IDLE:    if (!i_drain) state_d = ACTIVE;
         default: state_d = ACTIVE;
      endcase
   end

   always_comb begin
      req_ack = 1'b0;
      drained = 1'b0;
      case (state_q)
         ACTIVE:  req_ack = rst && bus.i_req_vld && !full;
         IDLE:    drained = 1'b1;
         default: ;
      endcase
   end

   assign bus.o_req_ack = req_ack;
   assign o_drained     = drained;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr[AW-1:0]] <= {bus.i_req_nodenum, bus.i_req_payload};
   end

   assign head               = mem[rd_ptr[AW-1:0]];
   assign bus.o_node_vld     = !empty;
   assign bus.o_node_payload = head[PAYLOAD_WIDTH-1:0];
   assign bus.o_node_tag     = head[EW-1:PAYLOAD_WIDTH];

`ifdef REQ_NODESET_SINK_STATS_EN
   logic [15:0] stat_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_q <= '0;
      end else if (push && stat_q != 16'hFFFF) begin
         stat_q <= stat_q + 16'd1;
      end
   end

   assign o_stat_accepted = stat_q;
`else
   assign o_stat_accepted = 16'h0000;
`endif
endmodule

// File: tb/tb_req_nodeset_sink.sv
// tb/tb_req_nodeset_sink.sv - directed self-checking bench for req_nodeset_sink
module tb_req_nodeset_sink;
   logic        clk = 1'b0;
   logic        rst;
   logic        drain;
   logic        drained;
   logic [2:0]  count;
   logic [15:0] stat;

   req_nodeset_sink_if #(.PAYLOAD_WIDTH(16), .NODETAG_WIDTH(6)) bus ();

   req_nodeset_sink #(.PAYLOAD_WIDTH(16), .NODETAG_WIDTH(6), .FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .i_drain         (drain),
      .o_drained       (drained),
      .o_count         (count),
      .o_stat_accepted (stat)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_acc   = 0;
   int          n       = 0;
   logic [21:0] sb [$];
   logic        obs_ack, obs_vld, obs_drained;
   logic [15:0] obs_pl;
   logic [5:0]  obs_tag;
   logic [2:0]  obs_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive, sample on the falling edge, score pops and pushes
   task automatic cyc(input logic vld, input logic [15:0] pl, input logic [5:0] tg,
                      input logic nack, input logic drn);
      bus.i_req_vld     = vld;
      bus.i_req_payload = pl;
      bus.i_req_nodenum = tg;
      bus.i_node_ack    = nack;
      drain             = drn;
      @(negedge clk);
      obs_ack     = bus.o_req_ack;
      obs_vld     = bus.o_node_vld;
      obs_pl      = bus.o_node_payload;
      obs_tag     = bus.o_node_tag;
      obs_cnt     = count;
      obs_drained = drained;
      if (rst && obs_vld && nack) begin
         if (sb.size() == 0) check("spurious_pop", 32'd1, 32'd0);
         else                check("order", {10'd0, obs_tag, obs_pl}, {10'd0, sb.pop_front()});
      end
      if (obs_ack) begin
         sb.push_back({tg, pl});
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drain = 1'b0;
      bus.i_req_vld = 1'b0;
      bus.i_req_payload = '0;
      bus.i_req_nodenum = '0;
      bus.i_node_ack = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 16'h1111, 6'd1, 1'b0, 1'b0);
      check("rst_ack", {31'd0, obs_ack}, 32'd0);
      check("rst_vld", {31'd0, obs_vld}, 32'd0);
      check("rst_cnt", {29'd0, obs_cnt}, 32'd0);
      check("rst_drained", {31'd0, obs_drained}, 32'd0);
      check("rst_stat", {16'd0, stat}, 32'd0);
      rst = 1'b1;
      sb.delete();
      n_acc = 0;

      // single request flows through with one cycle latency
      cyc(1'b1, 16'hA5A5, 6'd17, 1'b1, 1'b0);
      check("single_ack", {31'd0, obs_ack}, 32'd1);
      check("single_vld0", {31'd0, obs_vld}, 32'd0);
      cyc(1'b0, 16'h0000, 6'd0, 1'b1, 1'b0);
      check("single_vld1", {31'd0, obs_vld}, 32'd1);
      check("single_pl", {16'd0, obs_pl}, 32'hA5A5);
      check("single_tag", {26'd0, obs_tag}, 32'd17);
      check("single_cnt1", {29'd0, obs_cnt}, 32'd1);
      cyc(1'b0, 16'h0000, 6'd0, 1'b0, 1'b0);
      check("single_cnt2", {29'd0, obs_cnt}, 32'd0);
      check("single_vld2", {31'd0, obs_vld}, 32'd0);

      // fill without draining: exactly four accepted
      n = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 16'h0100 + 16'(n), 6'(n), 1'b0, 1'b0);
         if (obs_ack) n++;
      end
      check("fill_acks", n, 32'd4);
      check("fill_cnt", {29'd0, count}, 32'd4);
      check("fill_ack_off", {31'd0, obs_ack}, 32'd0);

      // full with push and pop requested: pop only
      cyc(1'b1, 16'h0104, 6'd4, 1'b1, 1'b0);
      check("full_noack", {31'd0, obs_ack}, 32'd0);
      check("full_head", {16'd0, obs_pl}, 32'h0100);

      // steady push+pop across many pointer wraps
      for (int i = 0; i < 90; i++) begin
         cyc(1'b1, 16'h0200 + 16'(i), 6'(i), 1'b1, 1'b0);
         check("steady_cnt", {29'd0, obs_cnt}, 32'd3);
         check("steady_ack", {31'd0, obs_ack}, 32'd1);
      end

      // drain with three entries stored
      cyc(1'b0, 16'h0000, 6'd0, 1'b0, 1'b1);
      check("drn_cnt3", {29'd0, obs_cnt}, 32'd3);
      check("drn_not_done", {31'd0, obs_drained}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 16'hDEAD, 6'd9, 1'b1, 1'b1);
         check("drn_noack", {31'd0, obs_ack}, 32'd0);
         check("drn_cnt", {29'd0, obs_cnt}, 32'(3 - i));
      end
      cyc(1'b1, 16'hDEAD, 6'd9, 1'b1, 1'b1);
      check("drn_cnt0", {29'd0, obs_cnt}, 32'd0);
      check("drn_not_yet", {31'd0, obs_drained}, 32'd0);
      cyc(1'b1, 16'hDEAD, 6'd9, 1'b1, 1'b1);
      check("drn_done", {31'd0, obs_drained}, 32'd1);
      check("drn_idle_noack", {31'd0, obs_ack}, 32'd0);
      check("drn_idle_vld", {31'd0, obs_vld}, 32'd0);
      cyc(1'b1, 16'h0300, 6'd30, 1'b0, 1'b0);
      check("resume_idle_noack", {31'd0, obs_ack}, 32'd0);
      check("resume_idle_drained", {31'd0, obs_drained}, 32'd1);
      cyc(1'b1, 16'h0300, 6'd30, 1'b0, 1'b0);
      check("resume_ack", {31'd0, obs_ack}, 32'd1);
      check("resume_drained", {31'd0, obs_drained}, 32'd0);
      cyc(1'b1, 16'h0301, 6'd31, 1'b0, 1'b0);
      check("two_stored", {29'd0, count}, 32'd2);

      // reset mid-operation discards stored entries
      rst = 1'b0;
      cyc(1'b1, 16'h0302, 6'd32, 1'b0, 1'b0);
      check("mid_rst_ack", {31'd0, obs_ack}, 32'd0);
      rst = 1'b1;
      sb.delete();
      n_acc = 0;
      cyc(1'b0, 16'h0000, 6'd0, 1'b0, 1'b0);
      check("post_rst_vld", {31'd0, obs_vld}, 32'd0);
      check("post_rst_cnt", {29'd0, obs_cnt}, 32'd0);
      check("post_rst_stat", {16'd0, stat}, 32'd0);
      cyc(1'b1, 16'h7777, 6'd3, 1'b0, 1'b0);
      cyc(1'b0, 16'h0000, 6'd0, 1'b1, 1'b0);
      check("fresh_head", {16'd0, obs_pl}, 32'h7777);
      check("fresh_tag", {26'd0, obs_tag}, 32'd3);
      check("fresh_cnt", {29'd0, obs_cnt}, 32'd1);

`ifdef REQ_NODESET_SINK_STATS_EN
      check("stat_small", {16'd0, stat}, 32'd1);
      for (int i = 0; i < 70000; i++) begin
         cyc(1'b1, 16'(i), 6'(i), 1'b1, 1'b0);
      end
      check("stat_sat", {16'd0, stat}, 32'hFFFF);
`else
      check("stat_off", {16'd0, stat}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/req_nodeset_sink.md
REQ_NODESET_SINK -- requirements
Module: req_nodeset_sink

Interface
REQ-001: Parameter PAYLOAD_WIDTH, default 16, SHALL set the request payload width in bits.
REQ-002: Parameter NODETAG_WIDTH, default 6, SHALL set the width of the node tag within the destination nodeset.
REQ-003: Parameter FIFO_DEPTH, default 4, SHALL set the buffer entries; legal values are powers of two, >= 2.
REQ-004: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005: rst  input  1  reset, synchronous, active-low.
REQ-006: i_req_vld  input  1  network output holds a valid request.
REQ-007: i_req_payload  input  PAYLOAD_WIDTH  request payload.
REQ-008: i_req_nodenum  input  NODETAG_WIDTH  destination node tag.
REQ-009: o_req_ack  output  1  pop strobe to the network; this cycle's request is consumed.
REQ-010: o_node_vld  output  1  buffer head is valid toward the node array.
REQ-011: o_node_payload  output  PAYLOAD_WIDTH  head payload.
REQ-012: o_node_tag  output  NODETAG_WIDTH  head node tag.
REQ-013: i_node_ack  input  1  node array consumes the head this cycle.
REQ-014: i_drain  input  1  request to stop intake and empty the buffer.
REQ-015: o_drained  output  1  block is drained and idle.
REQ-016: o_count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-017: o_stat_accepted  output  16  saturating count of accepted requests.

Function
REQ-018: Storage SHALL be a circular FIFO with registered read/write pointers one bit wider than the index; full = index bits equal and MSBs differ; empty = pointers equal.
REQ-019: o_req_ack SHALL equal i_req_vld AND (o_count < FIFO_DEPTH) AND state==ACTIVE; it SHALL NOT depend on i_node_ack (no pass-through when full).
REQ-020: An asserted o_req_ack SHALL write {i_req_nodenum, i_req_payload} at the write pointer at that clock edge.
REQ-021: o_node_vld SHALL be high whenever o_count != 0; o_node_payload/o_node_tag SHALL show the entry at the read pointer.
REQ-022: A pop SHALL occur when o_node_vld AND i_node_ack; i_node_ack with o_node_vld low SHALL be ignored.
REQ-023: Latency: a request accepted at edge N SHALL be presented on o_node_vld in the cycle following edge N.
REQ-024: Simultaneous push and pop SHALL leave o_count unchanged and SHALL preserve FIFO order.
REQ-025: Pointers SHALL wrap modulo 2*FIFO_DEPTH without loss or duplication.
REQ-026: Head outputs SHALL be held stable while o_node_vld is high and i_node_ack is low.
REQ-027: FSM states: ACTIVE, DRAIN, IDLE.
REQ-028: ACTIVE -> DRAIN when i_drain=1; intake stops in the same cycle i_drain is sampled high in ACTIVE only from the next cycle (registered state).
REQ-029: DRAIN -> IDLE when registered o_count==0; DRAIN -> ACTIVE when i_drain=0 (takes priority over IDLE).
REQ-030: IDLE -> ACTIVE when i_drain=0; otherwise stay IDLE.
REQ-031: o_drained SHALL be 1 only in IDLE; o_req_ack SHALL be 0 in DRAIN and IDLE; pops SHALL continue in DRAIN.

Reset
REQ-032: When rst=0 at a clock edge: pointers 0, o_count 0, state ACTIVE, o_stat_accepted 0.
REQ-033: During and after reset: o_node_vld 0, o_req_ack 0 while rst=0, o_drained 0; FIFO contents SHALL be discarded without being emitted.
REQ-034: Reset asserted mid-operation SHALL take priority over push, pop and FSM transitions in that cycle.

Configuration
REQ-035: Macro REQ_NODESET_SINK_STATS_EN defined: o_stat_accepted SHALL increment on each o_req_ack, saturating at 16'hFFFF.
REQ-036: Macro undefined: o_stat_accepted SHALL be constant 0 and no counter register SHALL be synthesized; all other behaviour identical.

Verification
REQ-037: Single request payload 16'hA5A5, tag 6'd17, i_node_ack=1 -> o_req_ack in cycle 0, o_node_vld with A5A5/17 in cycle 1, o_count back to 0 in cycle 2.
REQ-038: i_req_vld held high, i_node_ack=0, depth 4 -> exactly 4 acks, o_count=4, o_req_ack=0 thereafter; then i_node_ack=1 -> payloads emerge in order.
REQ-039: Full buffer, i_req_vld=1 and i_node_ack=1 -> no ack in full cycle; next cycle o_count=3 and one push accepted, o_count stays 3 under continuous push+pop, order preserved across >=10 pointer wraps.
REQ-040: 3 entries stored, i_drain=1 -> o_req_ack=0 despite i_req_vld, 3 pops, o_drained=1 one cycle after o_count=0; i_drain=0 -> ACTIVE, acks resume.
REQ-041: rst=0 with 2 entries stored -> next cycle o_node_vld=0, o_count=0, o_stat_accepted=0; post-reset no stale entry emitted.
REQ-042: With STATS_EN, 70000 accepted requests -> o_stat_accepted=16'hFFFF; without STATS_EN -> 0.
